// File: rtl/encrypt_shift_engine.sv
// encrypt_shift_engine: two-stage Caesar-shift pipeline with a loadable key.
//
// Optional feature: define ENCRYPT_KEY_ROLL_EN to build the 8-slot rolling key.
// When it is defined, the slot index steps on every encrypted alphabetic character.
// When it is undefined, every character uses slot 0 and no index counter is built.
//
// Ports
//   clk_i                       clock, all state on the rising edge
//   rst_ni                      asynchronous active-low reset
//   en_i / in_ready_o           input handshake; a transfer is en_i && in_ready_o
//   data_in_i [7:0]             ASCII plaintext character
//   shift_en_i                  1 = encrypt alphabetic characters, 0 = pass through
//   key_load_i / key_in_i[23:0] load eight 3-bit shift amounts; slot k = key_in_i[3k+2:3k]
//   out_ready_i                 downstream accepts the output
//   en_out_o / data_out_o[7:0]  registered output valid and ciphertext character
//   is_alpha_upper_case_out_o   original character was 'A'..'Z'
//   is_alpha_low_case_out_o     original character was 'a'..'z'
// in_ready_o is combinational: it depends on key_load_i and on output backpressure.
module encrypt_shift_engine (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic        in_ready_o,
    input  logic [7:0]  data_in_i,
    input  logic        shift_en_i,
    input  logic        key_load_i,
    input  logic [23:0] key_in_i,
    input  logic        out_ready_i,
    output logic        en_out_o,
    output logic [7:0]  data_out_o,
    output logic        is_alpha_upper_case_out_o,
    output logic        is_alpha_low_case_out_o
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned KEY_W  = 24;
    localparam int unsigned AMT_W  = 3;
    localparam int unsigned ROT_W  = 6;   // holds offset 0..25 plus amt 0..7
    localparam int unsigned ALPHA_N = 26;

    localparam logic [DATA_W-1:0] UPPER_LO = DATA_W'(65);
    localparam logic [DATA_W-1:0] UPPER_HI = DATA_W'(90);
    localparam logic [DATA_W-1:0] LOWER_LO = DATA_W'(97);
    localparam logic [DATA_W-1:0] LOWER_HI = DATA_W'(122);

    // Key schedule state
    logic [KEY_W-1:0]  key_q, key_d;
    logic [AMT_W-1:0]  amt_c;

    // Stage 1: classified character with its captured shift amount
    logic              s1_v_q, s1_v_d;
    logic [DATA_W-1:0] s1_char_q, s1_char_d;
    logic              s1_upper_q, s1_upper_d;
    logic              s1_lower_q, s1_lower_d;
    logic [AMT_W-1:0]  s1_amt_q, s1_amt_d;

    // Stage 2: registered outputs
    logic              s2_v_q, s2_v_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              s2_upper_q, s2_upper_d;
    logic              s2_lower_q, s2_lower_d;

    // Handshake and classification
    logic              s2_load_c;
    logic              s1_adv_c;
    logic              transfer_c;
    logic              in_upper_c;
    logic              in_lower_c;
    logic              in_alpha_c;
    logic              encrypt_c;

    // Rotation datapath on stage 1
    logic [DATA_W-1:0] base_c;
    logic [ROT_W-1:0]  off_c;
    logic [ROT_W-1:0]  sum_c;
    logic [ROT_W-1:0]  rot_c;
    logic [DATA_W-1:0] enc_c;

    // Flow control: S2 refills when empty or drained, S1 follows it.
    assign s2_load_c  = !s2_v_q || out_ready_i;
    assign s1_adv_c   = s1_v_q && s2_load_c;
    assign in_ready_o = rst_ni && !key_load_i && (!s1_v_q || s1_adv_c);
    assign transfer_c = en_i && in_ready_o;

    assign in_upper_c = (data_in_i >= UPPER_LO) && (data_in_i <= UPPER_HI);
    assign in_lower_c = (data_in_i >= LOWER_LO) && (data_in_i <= LOWER_HI);
    assign in_alpha_c = in_upper_c || in_lower_c;
    assign encrypt_c  = in_alpha_c && shift_en_i;

`ifdef ENCRYPT_KEY_ROLL_EN
    logic [2:0] idx_q, idx_d;
    logic [4:0] slot_lsb_c;

    assign slot_lsb_c = 5'(idx_q) * 5'd3;
    assign amt_c      = key_q[slot_lsb_c +: AMT_W];

    // Slot index: reset by a key load, steps only on encrypted characters, wraps 7 -> 0.
    always_comb begin
        idx_d = idx_q;
        if (key_load_i) begin
            idx_d = 3'd0;
        end else if (transfer_c && encrypt_c) begin
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= 3'd0;
        end else begin
            idx_q <= idx_d;
        end
    end
`else
    logic key_hi_unused_c;

    // Fixed key: slot 0 only; the upper slots are stored but never selected.
    assign amt_c           = key_q[AMT_W-1:0];
    assign key_hi_unused_c = ^key_q[KEY_W-1:AMT_W];
`endif

    // Caesar rotate-up within the character's own case.
    always_comb begin
        base_c = s1_upper_q ? UPPER_LO : LOWER_LO;
        off_c  = ROT_W'(s1_char_q - base_c);
        sum_c  = off_c + ROT_W'(s1_amt_q);
        rot_c  = (sum_c >= ROT_W'(ALPHA_N)) ? (sum_c - ROT_W'(ALPHA_N)) : sum_c;
        enc_c  = (s1_upper_q || s1_lower_q) ? (base_c + DATA_W'(rot_c)) : s1_char_q;
    end

    // Next-state for key, stage 1 and stage 2.
    always_comb begin
        key_d      = key_q;
        s1_v_d     = s1_v_q;
        s1_char_d  = s1_char_q;
        s1_upper_d = s1_upper_q;
        s1_lower_d = s1_lower_q;
        s1_amt_d   = s1_amt_q;
        s2_v_d     = s2_v_q;
        s2_data_d  = s2_data_q;
        s2_upper_d = s2_upper_q;
        s2_lower_d = s2_lower_q;

        if (key_load_i) begin
            key_d = key_in_i;
        end

        // Pass-through characters carry amt 0 so the rotation leaves them unchanged.
        if (transfer_c) begin
            s1_v_d     = 1'b1;
            s1_char_d  = data_in_i;
            s1_upper_d = in_upper_c;
            s1_lower_d = in_lower_c;
            s1_amt_d   = encrypt_c ? amt_c : AMT_W'(0);
        end else if (s1_adv_c) begin
            s1_v_d = 1'b0;
        end

        // Outputs are zeroed when S2 empties so idle cycles show a clean bus.
        if (s2_load_c) begin
            s2_v_d     = s1_v_q;
            s2_data_d  = s1_v_q ? enc_c : DATA_W'(0);
            s2_upper_d = s1_v_q && s1_upper_q;
            s2_lower_d = s1_v_q && s1_lower_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q      <= '0;
            s1_v_q     <= 1'b0;
            s1_char_q  <= '0;
            s1_upper_q <= 1'b0;
            s1_lower_q <= 1'b0;
            s1_amt_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_data_q  <= '0;
            s2_upper_q <= 1'b0;
            s2_lower_q <= 1'b0;
        end else begin
            key_q      <= key_d;
            s1_v_q     <= s1_v_d;
            s1_char_q  <= s1_char_d;
            s1_upper_q <= s1_upper_d;
            s1_lower_q <= s1_lower_d;
            s1_amt_q   <= s1_amt_d;
            s2_v_q     <= s2_v_d;
            s2_data_q  <= s2_data_d;
            s2_upper_q <= s2_upper_d;
            s2_lower_q <= s2_lower_d;
        end
    end

    assign en_out_o                  = s2_v_q;
    assign data_out_o                = s2_data_q;
    assign is_alpha_upper_case_out_o = s2_upper_q;
    assign is_alpha_low_case_out_o   = s2_lower_q;

endmodule

// File: doc/encrypt_shift_engine.md
ENCRYPT_SHIFT_ENGINE -- requirements
Module: encrypt_shift_engine

Interface
REQ-001 clk  in  1  single clock; all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 en  in  1  input character valid.
REQ-004 in_ready  out  1  engine accepts character this cycle; transfer = en && in_ready.
REQ-005 data_in  in  8  ASCII plaintext character.
REQ-006 shift_en  in  1  1 = encrypt alphabetic characters, 0 = pass through; sampled with data_in.
REQ-007 key_load  in  1  load key schedule this cycle.
REQ-008 key_in  in  24  eight 3-bit shift amounts; slot k = key_in[3k+2:3k].
REQ-009 out_ready  in  1  downstream accepts output.
REQ-010 en_out  out  1  output valid.
REQ-011 data_out  out  8  ciphertext character.
REQ-012 is_alpha_upper_case_out / is_alpha_low_case_out  out  1 each  class of the original character, aligned with data_out.

Function
REQ-013 Two-stage pipeline: S1 holds the classified character plus its shift amount; S2 holds the registered output.
REQ-014 Class: 65..90 upper, 97..122 lower, else non-alpha.
REQ-015 Encryption of an alphabetic character shall be a Caesar rotate-up within its case: out = base + ((c - base + amt) mod 26), with base 65 or 97 and amt 0..7.
REQ-016 Pass-through cases output data_in unchanged:
- non-alpha characters;
- shift_en=0;
- amt=0.
REQ-017 Both class flags shall be 0 for non-alpha characters.
REQ-018 Key register key_q (24b) and slot index idx (3b).
REQ-019 amt = key_q[3*idx+2 : 3*idx], captured into S1 at transfer.
REQ-020 Latency: an accepted character appears on en_out/data_out exactly 2 cycles after transfer when out_ready stays 1; throughput 1 char/cycle.
REQ-021 S2 loads when it is empty or out_ready=1.
REQ-022 S1 advances to S2 when S2 loads.
REQ-023 in_ready = !key_load && (S1 empty || S1 advancing).
REQ-024 With en_out=1 and out_ready=0, data_out, en_out and flags shall hold stable.
REQ-025 No character shall be lost or duplicated under any out_ready pattern.
REQ-026 key_load=1: key_q <= key_in and idx <= 0 at the next edge.
REQ-027 in_ready=0 during the key_load cycle; characters already in S1/S2 keep their captured amt.
REQ-028 idx advances only on a transfer of an alphabetic character with shift_en=1, wrapping 7 -> 0 (per Configuration).
REQ-029 Non-alpha and shift_en=0 transfers shall not advance idx.

Reset
REQ-030 While rst=0, the following shall be 0:
- en_out, data_out, both flags;
- S1/S2 valid bits;
- key_q, idx.
REQ-031 While rst=0, in_ready=0.
REQ-032 Reset mid-operation shall discard in-flight characters with no output after release.
REQ-033 in_ready shall be 1 on the first cycle after release when key_load=0.

Configuration
REQ-034 Macro ENCRYPT_KEY_ROLL_EN:
- defined: idx rolls per REQ-028 (8-slot rolling key);
- undefined: idx is held at 0, amt = key_q[2:0] for every character, and the idx counter is not built.

Verification
REQ-035 key_load key_in[2:0]=3, then 'A'(65), out_ready=1 -> data_out 'D'(68), upper flag 1, 2 cycles after transfer.
REQ-036 amt=1, 'z'(122) -> 'a'(97), lower flag 1 (wrap-around).
REQ-037 Rolling key, ROLL_EN defined:
- stimulus: key slots 0..2 = 1,2,3; send "a5aa";
- required response: "b5cd", idx=3 after.
- undefined: same stimulus -> "b5bb".
REQ-038 Backpressure:
- stimulus: out_ready=0 for 4 cycles while sending 'B','C','D' back-to-back with amt=2;
- required response: in_ready drops after 2 accepted; after release, outputs 'D','E','F' in order with no gaps or repeats.
REQ-039 key_load asserted together with en=1 -> in_ready=0 that cycle, character retried next cycle uses the new key_q slot 0.
REQ-040 rst=0 while S1 and S2 are both full -> en_out=0 immediately; no stale output after release.
